mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: an instruction fetch port and a data load/store port
// share one memory port, with one transaction outstanding at a time.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no transaction; arbitrate and latch the winner's request
// S_ISSUE     | mem_req high with latched we/addr/wdata until mem_ready
// S_WAIT_RESP | read accepted; wait for mem_rvalid to capture read data
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [SW-1:0] r_streak;
   logic          r_owner_d;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_if_gnt;
   logic          r_d_gnt;
   logic          r_if_done;
   logic          r_d_done;
   logic [31:0]   r_if_rdata;
   logic [31:0]   r_d_rdata;
   logic          w_grant_if;
   logic          w_grant_d;
   logic          w_done;
   logic          w_capture;
   logic          w_issue;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_if  = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Data normally wins; a saturated streak hands the next slot to fetch.
            if (d_req && !(if_req && (r_streak == LIMIT))) begin
               w_grant_d   = 1'b1;
               w_state_nxt = S_ISSUE;
            end else if (if_req) begin
               w_grant_if  = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               if (r_we) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_WAIT_RESP;
               end
            end
         end
         S_WAIT_RESP: begin
            if (mem_rvalid) begin
               w_capture   = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_streak   <= '0;
         r_owner_d  <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_gnt   <= 1'b0;
         r_d_gnt    <= 1'b0;
         r_if_done  <= 1'b0;
         r_d_done   <= 1'b0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_if_gnt  <= w_grant_if;
         r_d_gnt   <= w_grant_d;
         r_if_done <= w_done && !r_owner_d;
         r_d_done  <= w_done && r_owner_d;
         if (w_grant_d) begin
            r_owner_d <= 1'b1;
            r_we      <= d_we;
            r_addr    <= d_addr;
            r_wdata   <= d_wdata;
            if (!if_req)               r_streak <= '0;
            else if (r_streak != LIMIT) r_streak <= r_streak + SW'(1);
         end else if (w_grant_if) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= if_addr;
            r_wdata   <= '0;
            r_streak  <= '0;
         end
         if (w_capture) begin
            if (r_owner_d) r_d_rdata  <= mem_rdata;
            else           r_if_rdata <= mem_rdata;
         end
      end
   end

   assign w_issue   = (r_state == S_ISSUE);
   assign mem_req   = w_issue;
   assign mem_we    = w_issue ? r_we    : 1'b0;
   assign mem_addr  = w_issue ? r_addr  : 32'd0;
   assign mem_wdata = w_issue ? r_wdata : 32'd0;
   assign busy      = (r_state != S_IDLE);
   assign if_gnt    = r_if_gnt;
   assign d_gnt     = r_d_gnt;
   assign if_done   = r_if_done;
   assign d_done    = r_d_done;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch read, stalled store, back-to-back loads,
// fetch starvation limit under contention, and reset mid-transaction.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_done;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_done;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] exp_d;
      int         n;
      exp_d = 10'b0111101111;

      reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_gnt", {if_gnt, d_gnt, if_done, d_done}, 0);
      chk("rst_rdata", if_rdata | d_rdata, 0);
      reset = 1'b1;

      // fetch read, zero-wait memory
      if_req = 1; if_addr = 32'h100;
      tick();
      chk("fr_c1_if_gnt", if_gnt, 1);
      chk("fr_c1_d_gnt", d_gnt, 0);
      chk("fr_c1_mem_req", mem_req, 1);
      chk("fr_c1_mem_addr", mem_addr, 32'h100);
      chk("fr_c1_mem_we", mem_we, 0);
      if_req = 0; mem_ready = 1;
      tick();
      chk("fr_c2_if_gnt", if_gnt, 0);
      chk("fr_c2_mem_req", mem_req, 0);
      chk("fr_c2_mem_addr", mem_addr, 0);
      chk("fr_c2_busy", busy, 1);
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      chk("fr_c3_if_done", if_done, 1);
      chk("fr_c3_d_done", d_done, 0);
      chk("fr_c3_if_rdata", if_rdata, 32'hDEADBEEF);
      chk("fr_c3_busy", busy, 0);
      mem_rvalid = 0;
      tick();
      chk("fr_c4_if_done", if_done, 0);

      // data store with memory stall; a stray rvalid during ISSUE is ignored
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55;
      tick();
      chk("st_c1_d_gnt", d_gnt, 1);
      chk("st_c1_mem_we", mem_we, 1);
      chk("st_c1_mem_addr", mem_addr, 32'h200);
      d_req = 0; d_addr = 32'hFFFF; d_wdata = 32'hAAAA; mem_rvalid = 1;
      tick();
      chk("st_c2_d_gnt", d_gnt, 0);
      chk("st_c2_mem_addr", mem_addr, 32'h200);
      chk("st_c2_mem_wdata", mem_wdata, 32'h55);
      chk("st_c2_mem_req", mem_req, 1);
      mem_rvalid = 0;
      tick();
      chk("st_c3_mem_wdata", mem_wdata, 32'h55);
      chk("st_c3_d_done", d_done, 0);
      mem_ready = 1;
      tick();
      chk("st_c4_d_done", d_done, 1);
      chk("st_c4_d_rdata", d_rdata, 0);
      chk("st_c4_busy", busy, 0);
      chk("st_c4_mem_wdata", mem_wdata, 0);
      mem_ready = 0;

      // back-to-back loads
      d_req = 1; d_we = 0; d_addr = 32'h300;
      tick();
      chk("ld1_d_gnt", d_gnt, 1);
      chk("ld1_d_done", d_done, 0);
      d_req = 0; mem_ready = 1;
      tick();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h11112222;
      tick();
      chk("ld1_done", d_done, 1);
      chk("ld1_d_rdata", d_rdata, 32'h11112222);
      chk("ld1_if_rdata_kept", if_rdata, 32'hDEADBEEF);
      mem_rvalid = 0; d_req = 1; d_addr = 32'h304;
      tick();
      chk("ld2_d_gnt_no_gap", d_gnt, 1);
      chk("ld2_mem_addr", mem_addr, 32'h304);
      d_req = 0; mem_ready = 1;
      tick();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h33334444;
      tick();
      chk("ld2_done", d_done, 1);
      chk("ld2_d_rdata", d_rdata, 32'h33334444);
      mem_rvalid = 0;

      // contention: both requests held high, data stores vs fetch reads
      if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 1; d_addr = 32'h600;
      mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0;
      n = 0;
      for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
         tick();
         if (if_gnt || d_gnt) begin
            chk("ct_gnt_onehot", {if_gnt, d_gnt} == 2'b11, 0);
            chk($sformatf("ct_grant%0d_is_data", n), d_gnt, exp_d[n]);
            n++;
         end
         if (if_done || d_done) chk("ct_done_onehot", if_done & d_done, 0);
      end
      chk("ct_grant_count", n, 10);
      if_req = 0; d_req = 0;
      for (int cyc = 0; cyc < 20 && busy; cyc++) tick();
      chk("ct_idle", busy, 0);
      mem_ready = 0; mem_rvalid = 0;
      tick();

      // reset while waiting for read response
      if_req = 1; if_addr = 32'h400;
      tick();
      chk("rw_gnt", if_gnt, 1);
      if_req = 0; mem_ready = 1;
      tick();
      chk("rw_busy_wait", busy, 1);
      mem_ready = 0;
      reset = 1'b0;
      #1;
      chk("rw_rst_busy", busy, 0);
      chk("rw_rst_if_rdata", if_rdata, 0);
      chk("rw_rst_d_rdata", d_rdata, 0);
      tick();
      reset = 1'b1;
      mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
      tick();
      chk("rw_no_done_a", {if_done, d_done, if_gnt, d_gnt}, 0);
      chk("rw_busy_a", busy, 0);
      tick();
      chk("rw_no_done_b", {if_done, d_done}, 0);
      chk("rw_if_rdata", if_rdata, 0);
      chk("rw_d_rdata", d_rdata, 0);
      mem_rvalid = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
